// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, default bit divisor and
// the peripheral register map used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // 50 MHz / 9600 baud
  localparam int unsigned DIVISOR_DEFAULT = 5208;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001c;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIVISOR-1 while enabled, flags the last
// cycle of each bit (bit_end) and the cycle just before it (bit_near).
module uart_baud_gen #(
  parameter int unsigned DIVISOR = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic bit_end,
  output logic bit_near
);

  localparam int unsigned CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] NEAR = CW'(DIVISOR - 2);

  logic [CW-1:0] cnt;

  assign bit_end  = en && (cnt == LAST);
  assign bit_near = en && (cnt == NEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (clr || bit_end) cnt <= '0;
    else if (en)            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter with a one-byte holding register so software can
// queue the next byte while the current frame is on the line.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ovf,
  output logic       UART_TX
);

  tx_state_e  state, state_n;
  logic [7:0] shift, shift_n, hold, hold_n;
  logic [2:0] bit_cnt, bit_n;
  logic       hold_full, full_n;
  logic       line_n, ovf_n, done_n, consumed;
  logic       bit_end, bit_near, clr;

  assign clr = (state == IDLE) || (state_n != state);

  uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .en       (state != IDLE),
    .bit_end  (bit_end),
    .bit_near (bit_near)
  );

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    bit_n    = bit_cnt;
    hold_n   = hold;
    full_n   = hold_full;
    ovf_n    = 1'b0;
    consumed = 1'b0;
    case (state)
      IDLE:  if (tx_wr && !hold_full) begin
               shift_n  = tx_data;
               state_n  = START;
               consumed = 1'b1;
             end
      START: if (bit_end) begin
               state_n = DATA;
               bit_n   = 3'd0;
             end
      DATA:  if (bit_end) begin
               if (bit_cnt == 3'd7) state_n = STOP;
               else begin
                 shift_n = shift >> 1;
                 bit_n   = bit_cnt + 3'd1;
               end
             end
      STOP:  if (bit_end) begin
               if (hold_full) begin
                 shift_n = hold;
                 full_n  = 1'b0;
                 state_n = START;
               end else if (tx_wr) begin
                 shift_n  = tx_data;
                 state_n  = START;
                 consumed = 1'b1;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
    // Holding frees at the stop-bit end before the write is considered,
    // so a write on that edge refills it instead of overflowing.
    if (tx_wr && !consumed) begin
      if (full_n) ovf_n = 1'b1;
      else begin
        hold_n = tx_data;
        full_n = 1'b1;
      end
    end
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[0];
      default: line_n = 1'b1;
    endcase
    // Registered one cycle early so the pulse covers the final stop cycle.
    done_n = (state == STOP) && bit_near;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      UART_TX   <= 1'b1;
      tx_done   <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= full_n;
      bit_cnt   <= bit_n;
      UART_TX   <= line_n;
      tx_done   <= done_n;
      tx_ovf    <= ovf_n;
    end
  end

  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE) || hold_full;

endmodule
